// File: rtl/otn_pkg.sv
// Shared OTN framing definitions: FAS bytes, CRC-8 constants, receiver state
// encodings and the CRC-8 byte update.
package otn_pkg;

   localparam logic [7:0] FAS_0    = 8'hF6;
   localparam logic [7:0] FAS_1    = 8'hF6;
   localparam logic [7:0] FAS_2    = 8'h28;
   localparam logic [7:0] CRC_POLY = 8'h07;
   localparam logic [7:0] CRC_INIT = 8'h00;

   typedef enum logic [2:0] {
      StHunt,
      StPyld,
      StCrcb,
      StCheck,
      StDrain,
      StAck
   } rx_state_e;

   typedef enum logic [1:0] {
      RxIdle,
      RxStart,
      RxData,
      RxStop
   } byte_rx_state_e;

   // MSB-first, no reflection, no final XOR.
   function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/line_receiver_if.sv
// Payload byte stream from the line receiver to the client FIFO (valid/ready).
interface line_receiver_if;

   logic [7:0] pyld_data;
   logic       pyld_data_valid;
   logic       pyld_data_ready;

   modport master (
      output pyld_data,
      output pyld_data_valid,
      input  pyld_data_ready
   );

   modport slave (
      input  pyld_data,
      input  pyld_data_valid,
      output pyld_data_ready
   );

endinterface

// File: rtl/line_byte_rx.sv
// 8N1 byte receiver: 2-FF synchroniser, mid-bit sampling, glitch-rejecting start bit.
// o_framing_err is only meaningful alongside o_strobe.
module line_byte_rx
   import otn_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx,
   output logic [7:0] o_byte,
   output logic       o_strobe,
   output logic       o_framing_err
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   logic           meta_q, sync_q, prev_q;
   byte_rx_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     shift_q, shift_d;
   logic [7:0]     byte_q, byte_d;
   logic           strobe_q, strobe_d;
   logic           ferr_q, ferr_d;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         meta_q   <= 1'b1;
         sync_q   <= 1'b1;
         prev_q   <= 1'b1;
         state_q  <= RxIdle;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         byte_q   <= '0;
         strobe_q <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         meta_q   <= i_rx;
         sync_q   <= meta_q;
         prev_q   <= sync_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         byte_q   <= byte_d;
         strobe_q <= strobe_d;
         ferr_q   <= ferr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      bit_d    = bit_q;
      shift_d  = shift_q;
      byte_d   = byte_q;
      strobe_d = 1'b0;
      ferr_d   = 1'b0;
      case (state_q)
         RxIdle: begin
            cnt_d = '0;
            if (prev_q && !sync_q) state_d = RxStart;
         end
         RxStart: begin
            // A start bit that is high again at mid-bit was a glitch.
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = sync_q ? RxIdle : RxData;
            end
         end
         RxData: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shift_d = {sync_q, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) state_d = RxStop;
            end
         end
         RxStop: begin
            if (cnt_q == FULL_M1) begin
               cnt_d    = '0;
               byte_d   = shift_q;
               strobe_d = 1'b1;
               ferr_d   = !sync_q;
               state_d  = RxIdle;
            end
         end
         default: state_d = RxIdle;
      endcase
   end

   assign o_byte        = byte_q;
   assign o_strobe      = strobe_q;
   assign o_framing_err = ferr_q;

endmodule

// File: rtl/line_receiver.sv
// OTN line receiver: FAS hunt, one-frame payload buffer with CRC-8 check,
// valid/ready delivery to the client and an ACK pulse back to the sender.
module line_receiver
   import otn_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned PYLD_LEN     = 64,
   parameter int unsigned ACK_CYCLES   = 32,
   parameter int unsigned GAP_TIMEOUT  = 4096
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_otn_rx_data,
   output logic                   o_otn_tx_ack,
   input  logic                   i_arq_en,
   line_receiver_if.master        pyld,
   output logic [7:0]             o_crc_val,
   output logic                   o_crc_err,
   output logic [7:0]             o_frame_cnt
);

   localparam int unsigned PTR_W = $clog2(PYLD_LEN);
   localparam int unsigned GAP_W = $clog2(GAP_TIMEOUT + 1);
   localparam int unsigned ACK_W = $clog2(ACK_CYCLES + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(PYLD_LEN - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_CYCLES - 1);

   logic [7:0] rx_byte;
   logic       rx_strobe, rx_ferr;

   rx_state_e        state_q, state_d;
   logic [15:0]      fas_q, fas_d;
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [7:0]       crc_q, crc_d, rx_crc_q, rx_crc_d;
   logic             frm_err_q, frm_err_d;
   logic [7:0]       crc_val_q, crc_val_d;
   logic             crc_err_q, crc_err_d;
   logic [7:0]       frame_cnt_q, frame_cnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
   logic             buf_we, frame_good;
   logic [7:0]       buf_mem [PYLD_LEN];

   line_byte_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte_rx (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_rx         (i_otn_rx_data),
      .o_byte       (rx_byte),
      .o_strobe     (rx_strobe),
      .o_framing_err(rx_ferr)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= StHunt;
         fas_q       <= '0;
         wr_q        <= '0;
         rd_q        <= '0;
         crc_q       <= CRC_INIT;
         rx_crc_q    <= '0;
         frm_err_q   <= 1'b0;
         crc_val_q   <= '0;
         crc_err_q   <= 1'b0;
         frame_cnt_q <= '0;
         gap_q       <= '0;
         ack_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         fas_q       <= fas_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         crc_q       <= crc_d;
         rx_crc_q    <= rx_crc_d;
         frm_err_q   <= frm_err_d;
         crc_val_q   <= crc_val_d;
         crc_err_q   <= crc_err_d;
         frame_cnt_q <= frame_cnt_d;
         gap_q       <= gap_d;
         ack_cnt_q   <= ack_cnt_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (buf_we) buf_mem[wr_q] <= rx_byte;
   end

   assign frame_good = (rx_crc_q == crc_q) && !frm_err_q;

   always_comb begin
      state_d     = state_q;
      fas_d       = fas_q;
      wr_d        = wr_q;
      rd_d        = rd_q;
      crc_d       = crc_q;
      rx_crc_d    = rx_crc_q;
      frm_err_d   = frm_err_q;
      crc_val_d   = crc_val_q;
      crc_err_d   = crc_err_q;
      frame_cnt_d = frame_cnt_q;
      gap_d       = '0;
      ack_cnt_d   = ack_cnt_q;
      buf_we      = 1'b0;
      case (state_q)
         StHunt: begin
            if (rx_strobe) begin
               if (rx_ferr) begin
                  fas_d = '0;
               end else if ({fas_q, rx_byte} == {FAS_0, FAS_1, FAS_2}) begin
                  fas_d     = '0;
                  wr_d      = '0;
                  crc_d     = CRC_INIT;
                  frm_err_d = 1'b0;
                  state_d   = StPyld;
               end else begin
                  fas_d = {fas_q[7:0], rx_byte};
               end
            end
         end
         StPyld: begin
            if (rx_strobe) begin
               buf_we    = 1'b1;
               crc_d     = crc8_update(crc_q, rx_byte);
               frm_err_d = frm_err_q | rx_ferr;
               wr_d      = wr_q + 1'b1;
               if (wr_q == LAST_PTR) state_d = StCrcb;
            end else begin
               gap_d = gap_q + 1'b1;
               if (gap_q == GAP_LAST) state_d = StHunt;
            end
         end
         StCrcb: begin
            if (rx_strobe) begin
               rx_crc_d  = rx_byte;
               frm_err_d = frm_err_q | rx_ferr;
               crc_val_d = crc_q;
               state_d   = StCheck;
            end else begin
               gap_d = gap_q + 1'b1;
               if (gap_q == GAP_LAST) state_d = StHunt;
            end
         end
         StCheck: begin
            // Without ARQ a bad frame is still delivered, just flagged.
            if (frame_good || !i_arq_en) begin
               crc_err_d = !frame_good;
               rd_d      = '0;
               state_d   = StDrain;
            end else begin
               crc_err_d = 1'b1;
               state_d   = StHunt;
            end
         end
         StDrain: begin
            if (pyld.pyld_data_ready) begin
               if (rd_q == LAST_PTR) begin
                  frame_cnt_d = frame_cnt_q + 8'd1;
                  ack_cnt_d   = '0;
                  state_d     = i_arq_en ? StAck : StHunt;
               end else begin
                  rd_d = rd_q + 1'b1;
               end
            end
         end
         StAck: begin
            ack_cnt_d = ack_cnt_q + 1'b1;
            if (ack_cnt_q == ACK_LAST) state_d = StHunt;
         end
         default: state_d = StHunt;
      endcase
   end

   // Decoded straight from the state register so reset drops them without a clock.
   assign o_otn_tx_ack         = (state_q == StAck);
   assign pyld.pyld_data_valid = (state_q == StDrain);
   assign pyld.pyld_data       = (state_q == StDrain) ? buf_mem[rd_q] : 8'h00;
   assign o_crc_val            = crc_val_q;
   assign o_crc_err            = crc_err_q;
   assign o_frame_cnt          = frame_cnt_q;

endmodule

// File: tb/tb_line_receiver.sv
// Directed bench for line_receiver: serial frame driver, payload scoreboard,
// ACK/backpressure/timeout/reset checks.
module tb_line_receiver;

   localparam int unsigned CPB  = 8;
   localparam int unsigned PLEN = 64;
   localparam int unsigned ACKC = 32;
   localparam int unsigned GAPT = 4096;
   localparam logic [7:0] F_A = 8'hF6;
   localparam logic [7:0] F_B = 8'h28;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       line = 1'b1;
   logic       arq = 1'b1;
   logic       ack;
   logic [7:0] crc_val, frame_cnt;
   logic       crc_err;

   line_receiver_if pif ();

   line_receiver #(
      .CLKS_PER_BIT(CPB),
      .PYLD_LEN    (PLEN),
      .ACK_CYCLES  (ACKC),
      .GAP_TIMEOUT (GAPT)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_otn_rx_data(line),
      .o_otn_tx_ack (ack),
      .i_arq_en     (arq),
      .pyld         (pif),
      .o_crc_val    (crc_val),
      .o_crc_err    (crc_err),
      .o_frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] sb[$];
   logic [7:0] pl[PLEN];
   logic [7:0] exp_crc;
   int         ack_seen;
   int         acc_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bit-serial reference CRC-8, poly 0x07.
   function automatic logic [7:0] crc_bits(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r;
      logic       fb;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         fb = r[7] ^ d[i];
         r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return r;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      line = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         line = b[i];
         repeat (CPB) @(negedge clk);
      end
      line = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   // flip >= 0 corrupts bit 0 of that payload byte; the CRC byte stays the clean one.
   task automatic send_frame(input int flip, input bit push);
      logic [7:0] c_sent, c_rx, b;
      c_sent = 8'h00;
      c_rx   = 8'h00;
      send_byte(F_A);
      send_byte(F_A);
      send_byte(F_B);
      for (int i = 0; i < int'(PLEN); i++) begin
         b      = pl[i];
         c_sent = crc_bits(c_sent, b);
         if (i == flip) b[0] = ~b[0];
         c_rx = crc_bits(c_rx, b);
         if (push) sb.push_back(b);
         send_byte(b);
      end
      exp_crc = c_rx;
      send_byte(c_sent);
   endtask

   // rmode 0: ready always 1; 1: ready pattern 1-0-0-1.
   // stop 1: return after 5 ACK cycles; stop 2: return after 10 accepted bytes.
   task automatic watch(input int max_cyc, input int rmode, input int stop);
      logic [7:0] prev_data, exp_b;
      bit         prev_stall;
      prev_stall = 1'b0;
      prev_data  = 8'h00;
      ack_seen   = 0;
      acc_cnt    = 0;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (prev_stall) begin
            checks++;
            assert (pif.pyld_data_valid === 1'b1 && pif.pyld_data === prev_data) else begin
               errors++;
               $error("FAIL stall_hold: valid %b data %h expected valid 1 data %h",
                      pif.pyld_data_valid, pif.pyld_data, prev_data);
            end
         end
         if (ack === 1'b1) begin
            ack_seen++;
            checks++;
            assert (sb.size() === 0) else begin
               errors++;
               $error("FAIL ack_early: %0d bytes pending expected 0", sb.size());
            end
         end
         pif.pyld_data_ready = (rmode == 0) || (c % 4 == 0) || (c % 4 == 3);
         if (pif.pyld_data_valid === 1'b1 && pif.pyld_data_ready) begin
            acc_cnt++;
            checks++;
            assert (sb.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_byte: got %h expected none", pif.pyld_data);
            end
            if (sb.size() != 0) begin
               exp_b = sb.pop_front();
               checks++;
               assert (pif.pyld_data === exp_b) else begin
                  errors++;
                  $error("FAIL payload: got %h expected %h", pif.pyld_data, exp_b);
               end
            end
         end
         prev_stall = (pif.pyld_data_valid === 1'b1) && !pif.pyld_data_ready;
         prev_data  = pif.pyld_data;
         if (stop == 1 && ack_seen == 5) break;
         if (stop == 2 && acc_cnt == 10) break;
      end
   endtask

   initial begin
      pif.pyld_data_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ack", ack, 0);
      chk("rst_valid", pif.pyld_data_valid, 0);
      chk("rst_data", pif.pyld_data, 0);
      chk("rst_crc_val", crc_val, 0);
      chk("rst_crc_err", crc_err, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Good frame, ARQ on.
      for (int i = 0; i < int'(PLEN); i++) pl[i] = 8'(i);
      fork
         send_frame(-1, 1'b1);
         watch(5800, 0, 0);
      join
      chk("t1_drained", sb.size(), 0);
      chk("t1_ack_len", ack_seen, ACKC);
      chk("t1_crc_err", crc_err, 0);
      chk("t1_crc_val", crc_val, exp_crc);
      chk("t1_cnt", frame_cnt, 1);

      // Corrupted byte 5 with ARQ: dropped, then the resend is delivered.
      fork
         send_frame(5, 1'b0);
         watch(5800, 0, 0);
      join
      chk("t2_bad_ack", ack_seen, 0);
      chk("t2_bad_err", crc_err, 1);
      chk("t2_bad_crc_val", crc_val, exp_crc);
      chk("t2_bad_cnt", frame_cnt, 1);
      fork
         send_frame(-1, 1'b1);
         watch(5800, 0, 0);
      join
      chk("t2_drained", sb.size(), 0);
      chk("t2_ack_len", ack_seen, ACKC);
      chk("t2_err", crc_err, 0);
      chk("t2_cnt", frame_cnt, 2);

      // Same corruption with ARQ off: delivered anyway, flagged, no ACK.
      arq = 1'b0;
      fork
         send_frame(5, 1'b1);
         watch(5800, 0, 0);
      join
      chk("t3_drained", sb.size(), 0);
      chk("t3_ack", ack_seen, 0);
      chk("t3_err", crc_err, 1);
      chk("t3_cnt", frame_cnt, 3);
      arq = 1'b1;

      // Backpressure.
      for (int i = 0; i < int'(PLEN); i++) pl[i] = 8'(i * 5 + 3);
      fork
         send_frame(-1, 1'b1);
         watch(5800, 1, 0);
      join
      chk("t4_drained", sb.size(), 0);
      chk("t4_ack_len", ack_seen, ACKC);
      chk("t4_err", crc_err, 0);
      chk("t4_crc_val", crc_val, exp_crc);
      chk("t4_cnt", frame_cnt, 4);

      // Junk before the real FAS.
      fork
         begin
            send_byte(F_A);
            send_byte(F_B);
            send_byte(F_A);
            send_byte(F_A);
            send_frame(-1, 1'b1);
         end
         watch(6200, 0, 0);
      join
      chk("t5_drained", sb.size(), 0);
      chk("t5_ack_len", ack_seen, ACKC);
      chk("t5_cnt", frame_cnt, 5);

      // Line stalls 10 bytes into a frame.
      fork
         begin
            send_byte(F_A);
            send_byte(F_A);
            send_byte(F_B);
            for (int i = 0; i < 10; i++) send_byte(8'(i));
         end
         watch(13 * 10 * CPB + GAPT + 300, 0, 0);
      join
      chk("t5_to_ack", ack_seen, 0);
      chk("t5_to_delivered", acc_cnt, 0);
      chk("t5_to_err", crc_err, 0);
      chk("t5_to_cnt", frame_cnt, 5);

      // Reset during ACK.
      for (int i = 0; i < int'(PLEN); i++) pl[i] = 8'(i) ^ 8'hA5;
      fork
         send_frame(-1, 1'b1);
         watch(5800, 0, 1);
      join
      chk("t6_ack_reached", ack_seen, 5);
      #2 rst = 1'b1;
      #1;
      chk("t6_ack_async", ack, 0);
      chk("t6_cnt_rst", frame_cnt, 0);
      @(negedge clk) rst = 1'b0;
      sb.delete();
      repeat (5) @(negedge clk);

      // Reset during DRAIN.
      fork
         send_frame(-1, 1'b1);
         watch(5800, 0, 2);
      join
      chk("t6_drain_reached", acc_cnt, 10);
      chk("t6_valid_before", pif.pyld_data_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("t6_valid_async", pif.pyld_data_valid, 0);
      chk("t6_data_rst", pif.pyld_data, 0);
      @(negedge clk) rst = 1'b0;
      sb.delete();
      repeat (5) @(negedge clk);

      // Normal frame after reset.
      fork
         send_frame(-1, 1'b1);
         watch(5800, 0, 0);
      join
      chk("t6_drained", sb.size(), 0);
      chk("t6_ack_len", ack_seen, ACKC);
      chk("t6_err", crc_err, 0);
      chk("t6_crc_val", crc_val, exp_crc);
      chk("t6_cnt", frame_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
